// File: rtl/pc_gen_if.sv
// Fetch-stage bus between the pipeline control logic (master) and the
// program-counter generator (slave).
interface pc_gen_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned STALL_W = 6
);
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  new_pc;
    logic               branch_flag;
    logic [ADDR_W-1:0]  branch_target;
    logic               ce;
    logic [ADDR_W-1:0]  pc;
    logic               redirect;
    logic               misaligned;

    modport master (
        output stall, flush, new_pc, branch_flag, branch_target,
        input  ce, pc, redirect, misaligned
    );

    modport slave (
        input  stall, flush, new_pc, branch_flag, branch_target,
        output ce, pc, redirect, misaligned
    );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sequential increment, stall,
// branch/flush redirect and a one-entry pending-branch latch for stalled fetch.
module pc_gen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       PC_STEP   = 4,
    parameter int unsigned       STALL_W   = 6
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PC_STEP - 1);

    typedef enum logic {
        S_OFF = 1'b0,
        S_RUN = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              redirect_q, redirect_d;
    logic              misaligned_q, misaligned_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    // Only the PC-stage bit of the stall vector matters here.
    logic [STALL_W-1:0] stall_vec;
    logic               unused_stall;
    assign stall_vec    = bus.stall;
    assign unused_stall = ^stall_vec;

    // Next-state and update priority: flush > stall > branch > pending > increment.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redirect_d   = 1'b0;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        unique case (state_q)
            S_OFF: begin
                state_d = S_RUN;
                pc_d    = RESET_VEC;
            end
            S_RUN: begin
                if (bus.flush) begin
                    pc_d         = bus.new_pc;
                    pend_valid_d = 1'b0;
                    redirect_d   = 1'b1;
                end else if (stall_vec[0]) begin
                    if (bus.branch_flag) begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = bus.branch_target;
                    end
                end else if (bus.branch_flag) begin
                    pc_d         = bus.branch_target;
                    pend_valid_d = 1'b0;
                    redirect_d   = 1'b1;
                end else if (pend_valid_q) begin
                    pc_d         = pend_addr_q;
                    pend_valid_d = 1'b0;
                    redirect_d   = 1'b1;
                end else begin
                    pc_d = pc_q + STEP;
                end
            end
        endcase
        // Mask is zero when PC_STEP is 1, so the flag is tied low there.
        misaligned_d = |(pc_d & ALIGN_MASK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_OFF;
            pc_q         <= RESET_VEC;
            redirect_q   <= 1'b0;
            misaligned_q <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            misaligned_q <= misaligned_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

    assign bus.ce         = (state_q == S_RUN);
    assign bus.pc         = pc_q;
    assign bus.redirect   = redirect_q;
    assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a 32-bit instance for the main scenarios and an
// 8-bit instance for address wrap and mid-run reset.
module tb_pc_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst32;
    logic rst8;

    pc_gen_if #(.ADDR_W(32), .STALL_W(6)) bus32 ();
    pc_gen_if #(.ADDR_W(8),  .STALL_W(6)) bus8 ();

    pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0), .PC_STEP(4), .STALL_W(6)) dut32 (
        .clk(clk), .rst(rst32), .bus(bus32));
    pc_gen #(.ADDR_W(8), .RESET_VEC(8'h0), .PC_STEP(4), .STALL_W(6)) dut8 (
        .clk(clk), .rst(rst8), .bus(bus8));

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        br;
        logic [31:0] tgt;
    } stim_t;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
        logic        rd;
        logic        mis;
    } obs_t;

    obs_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic stim_t S(int r, int st, int fl, int np, int br, int tg);
        return '{1'(r), 1'(st), 1'(fl), 32'(np), 1'(br), 32'(tg)};
    endfunction

    function automatic obs_t E(int ce, int pc, int rd, int mis);
        return '{1'(ce), 32'(pc), 1'(rd), 1'(mis)};
    endfunction

    // Upper stall bits are randomised to show they are ignored.
    task automatic apply32(input stim_t s);
        rst32               = s.rst;
        bus32.stall         = {5'($urandom), s.stall};
        bus32.flush         = s.flush;
        bus32.new_pc        = s.new_pc;
        bus32.branch_flag   = s.br;
        bus32.branch_target = s.tgt;
    endtask

    task automatic apply8(input stim_t s);
        rst8               = s.rst;
        bus8.stall         = {5'($urandom), s.stall};
        bus8.flush         = s.flush;
        bus8.new_pc        = s.new_pc[7:0];
        bus8.branch_flag   = s.br;
        bus8.branch_target = s.tgt[7:0];
    endtask

    function automatic obs_t obs32();
        return '{bus32.ce, bus32.pc, bus32.redirect, bus32.misaligned};
    endfunction

    function automatic obs_t obs8();
        return '{bus8.ce, {24'h0, bus8.pc}, bus8.redirect, bus8.misaligned};
    endfunction

    task automatic test_reset();
        stim_t st[$]; obs_t ex[$]; obs_t got, exp;
        repeat (3) begin st.push_back(S(1, 0, 0, 0, 0, 0)); ex.push_back(E(0, 0, 0, 0)); end
        st.push_back(S(0, 0, 1, 'h80, 1, 'h200)); ex.push_back(E(1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 4, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 8, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 'hC, 0, 0));
        foreach (st[i]) begin
            apply32(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            exp = sb.pop_front(); got = obs32(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset[%0d] got ce=%0b pc=%h rd=%0b mis=%0b want ce=%0b pc=%h rd=%0b mis=%0b",
                         i, got.ce, got.pc, got.rd, got.mis, exp.ce, exp.pc, exp.rd, exp.mis);
            end
        end
    endtask

    task automatic test_stall();
        stim_t st[$]; obs_t ex[$]; obs_t got, exp;
        st.push_back(S(0, 0, 0, 0, 0, 0)); ex.push_back(E(1, 'h10, 0, 0));
        repeat (3) begin st.push_back(S(0, 1, 0, 0, 0, 0)); ex.push_back(E(1, 'h10, 0, 0)); end
        st.push_back(S(0, 0, 0, 0, 0, 0)); ex.push_back(E(1, 'h14, 0, 0));
        foreach (st[i]) begin
            apply32(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            exp = sb.pop_front(); got = obs32(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stall[%0d] got ce=%0b pc=%h rd=%0b mis=%0b want ce=%0b pc=%h rd=%0b mis=%0b",
                         i, got.ce, got.pc, got.rd, got.mis, exp.ce, exp.pc, exp.rd, exp.mis);
            end
        end
    endtask

    task automatic test_branch_stall();
        stim_t st[$]; obs_t ex[$]; obs_t got, exp;
        st.push_back(S(0, 0, 0, 0, 0, 0));       ex.push_back(E(1, 'h18, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));       ex.push_back(E(1, 'h1C, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));       ex.push_back(E(1, 'h20, 0, 0));
        st.push_back(S(0, 1, 0, 0, 1, 'h100));   ex.push_back(E(1, 'h20, 0, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0));       ex.push_back(E(1, 'h20, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));       ex.push_back(E(1, 'h100, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));       ex.push_back(E(1, 'h104, 0, 0));
        st.push_back(S(0, 1, 0, 0, 1, 'h300));   ex.push_back(E(1, 'h104, 0, 0));
        st.push_back(S(0, 1, 0, 0, 1, 'h400));   ex.push_back(E(1, 'h104, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));       ex.push_back(E(1, 'h400, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));       ex.push_back(E(1, 'h404, 0, 0));
        foreach (st[i]) begin
            apply32(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            exp = sb.pop_front(); got = obs32(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL branch_stall[%0d] got ce=%0b pc=%h rd=%0b mis=%0b want ce=%0b pc=%h rd=%0b mis=%0b",
                         i, got.ce, got.pc, got.rd, got.mis, exp.ce, exp.pc, exp.rd, exp.mis);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$]; obs_t ex[$]; obs_t got, exp;
        st.push_back(S(0, 1, 0, 0, 1, 'h500));   ex.push_back(E(1, 'h404, 0, 0));
        st.push_back(S(0, 0, 0, 0, 1, 'h600));   ex.push_back(E(1, 'h600, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));       ex.push_back(E(1, 'h604, 0, 0));
        st.push_back(S(0, 0, 0, 0, 1, 'h700));   ex.push_back(E(1, 'h700, 1, 0));
        st.push_back(S(0, 0, 0, 0, 1, 'h800));   ex.push_back(E(1, 'h800, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));       ex.push_back(E(1, 'h804, 0, 0));
        foreach (st[i]) begin
            apply32(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            exp = sb.pop_front(); got = obs32(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL back_to_back[%0d] got ce=%0b pc=%h rd=%0b mis=%0b want ce=%0b pc=%h rd=%0b mis=%0b",
                         i, got.ce, got.pc, got.rd, got.mis, exp.ce, exp.pc, exp.rd, exp.mis);
            end
        end
    endtask

    task automatic test_priority();
        stim_t st[$]; obs_t ex[$]; obs_t got, exp;
        st.push_back(S(0, 1, 1, 'h80, 1, 'h200)); ex.push_back(E(1, 'h80, 1, 0));
        st.push_back(S(0, 1, 0, 0, 0, 0));         ex.push_back(E(1, 'h80, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 'h84, 0, 0));
        st.push_back(S(0, 1, 0, 0, 1, 'h900));     ex.push_back(E(1, 'h84, 0, 0));
        st.push_back(S(0, 0, 1, 'hA0, 0, 0));      ex.push_back(E(1, 'hA0, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 'hA4, 0, 0));
        foreach (st[i]) begin
            apply32(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            exp = sb.pop_front(); got = obs32(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL priority[%0d] got ce=%0b pc=%h rd=%0b mis=%0b want ce=%0b pc=%h rd=%0b mis=%0b",
                         i, got.ce, got.pc, got.rd, got.mis, exp.ce, exp.pc, exp.rd, exp.mis);
            end
        end
    endtask

    task automatic test_misalign();
        stim_t st[$]; obs_t ex[$]; obs_t got, exp;
        st.push_back(S(0, 0, 0, 0, 1, 'h102));     ex.push_back(E(1, 'h102, 1, 1));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 'h106, 0, 1));
        st.push_back(S(0, 1, 0, 0, 0, 0));         ex.push_back(E(1, 'h106, 0, 1));
        st.push_back(S(0, 0, 1, 'h200, 0, 0));     ex.push_back(E(1, 'h200, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 'h204, 0, 0));
        foreach (st[i]) begin
            apply32(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            exp = sb.pop_front(); got = obs32(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL misalign[%0d] got ce=%0b pc=%h rd=%0b mis=%0b want ce=%0b pc=%h rd=%0b mis=%0b",
                         i, got.ce, got.pc, got.rd, got.mis, exp.ce, exp.pc, exp.rd, exp.mis);
            end
        end
    endtask

    task automatic test_wrap_reset();
        stim_t st[$]; obs_t ex[$]; obs_t got, exp;
        st.push_back(S(1, 0, 0, 0, 0, 0));         ex.push_back(E(0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 0, 0, 0));
        st.push_back(S(0, 0, 1, 'hF8, 0, 0));      ex.push_back(E(1, 'hF8, 1, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 'hFC, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 'h00, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 'h04, 0, 0));
        st.push_back(S(0, 1, 0, 0, 1, 'h40));      ex.push_back(E(1, 'h04, 0, 0));
        st.push_back(S(1, 1, 0, 0, 0, 0));         ex.push_back(E(0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 0, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 'h04, 0, 0));
        st.push_back(S(0, 0, 0, 0, 0, 0));         ex.push_back(E(1, 'h08, 0, 0));
        foreach (st[i]) begin
            apply8(st[i]); sb.push_back(ex[i]);
            @(posedge clk); #1;
            exp = sb.pop_front(); got = obs8(); vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL wrap_reset[%0d] got ce=%0b pc=%h rd=%0b mis=%0b want ce=%0b pc=%h rd=%0b mis=%0b",
                         i, got.ce, got.pc, got.rd, got.mis, exp.ce, exp.pc, exp.rd, exp.mis);
            end
        end
    endtask

    initial begin
        apply32(S(1, 0, 0, 0, 0, 0));
        apply8(S(1, 0, 0, 0, 0, 0));
        test_reset();
        test_stall();
        test_branch_stall();
        test_back_to_back();
        test_priority();
        test_misalign();
        test_wrap_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage. It drives the instruction-ROM chip enable and the fetch address.
- Beyond sequential increment, it supports:
  - pipeline stall
  - branch redirect
  - exception/flush redirect with priority
  - a one-entry pending-redirect latch, so a branch resolved while fetch is stalled is not lost
  - a misalignment flag for the exception logic

Parameters:
- ADDR_W, 32, width of pc, branch_target, new_pc.
- RESET_VEC, 32'h00000000, pc value while ce is low and on the first enabled cycle.
- PC_STEP, 4, sequential increment. Must be a power of two, at least 1.
- STALL_W, 6, width of the stall vector from the stall controller. Only bit 0 (PC stage) is used here.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- stall  in  STALL_W  stall vector. stall[0]=1 holds pc.
- flush  in  1  exception/flush request. Highest priority.
- new_pc  in  ADDR_W  flush target.
- branch_flag  in  1  branch/jump taken, from decode.
- branch_target  in  ADDR_W  branch target address.
- ce  out  1  ROM chip enable.
- pc  out  ADDR_W  fetch address.
- redirect  out  1  one-cycle pulse: pc was loaded from flush, branch or pending target in this update.
- misaligned  out  1  pc is not a multiple of PC_STEP. Registered with pc.

Behaviour:
- All state updates on posedge clk. No combinational input-to-output paths.
- Reset (rst=1 at an edge):
  - ce<=0, pc<=RESET_VEC, redirect<=0, misaligned<=0, pend_valid<=0, pend_addr<=0.
  - Reset overrides all other inputs, including mid-stall and mid-pending.
- State machine, 2 states:
  - OFF (ce=0): entered on reset. At the next edge with rst=0, goes to RUN and sets ce<=1. pc stays RESET_VEC. All other inputs are ignored in OFF, including flush and branch.
  - RUN (ce=1): stays in RUN until rst.
  - First enabled fetch: pc=RESET_VEC is presented with ce=1 for at least one cycle. The first increment occurs at the edge after ce first reads 1.
- RUN update priority, evaluated once per edge:
  1. flush=1: pc<=new_pc, pend_valid<=0, redirect<=1. This applies even when stall[0]=1.
  2. stall[0]=1: pc holds, redirect<=0.
     - If branch_flag=1: pend_valid<=1, pend_addr<=branch_target. A later branch during the same stall overwrites the latch (last wins).
  3. branch_flag=1: pc<=branch_target, pend_valid<=0, redirect<=1.
  4. pend_valid=1: pc<=pend_addr, pend_valid<=0, redirect<=1.
  5. Otherwise: pc<=pc+PC_STEP, modulo 2^ADDR_W (wraps from all-ones region to low addresses, no flag), redirect<=0.
- Latency:
  - A redirect or flush is visible on pc exactly one cycle after the input is sampled.
  - A pending target is visible one cycle after the first edge with stall[0]=0.
- misaligned:
  - Registered from the value being loaded into pc: 1 iff its low log2(PC_STEP) bits are nonzero.
  - pc is still loaded unmodified. Exception raising is downstream.
  - Tied to 0 when PC_STEP=1.
- Simultaneous events:
  - flush with branch_flag: flush wins and the branch is dropped.
  - flush with pend_valid: the pending entry is cleared.
  - branch_flag with pend_valid when not stalled: the new branch wins and the pending entry is cleared.

Test Plan:
- Reset/start: rst=1 for 3 cycles, then 0.
  - ce=0 and pc=0 during reset.
  - First cycle after reset: ce=1, pc=0.
  - Following cycles: pc=4, 8, 12.
- Stall: stall=6'b000001 for 3 cycles at pc=0x10.
  - pc stays 0x10 for 3 cycles, then 0x14.
  - redirect=0 throughout.
- Branch during stall: at pc=0x20, stall[0]=1 with branch_flag=1, target 0x100, one cycle.
  - pc holds 0x20 while stalled.
  - After stall drops: pc=0x100, redirect=1 for one cycle, then pc=0x104.
- Priority: flush=1 (new_pc=0x80) with branch_flag=1 (0x200) and stall[0]=1.
  - Next pc=0x80, redirect=1.
  - The pending entry is cleared, so pc never becomes 0x200.
- Misalignment: branch_target=0x102.
  - pc=0x102 with misaligned=1.
  - Next cycle pc=0x106 with misaligned=1.
  - Then flush to 0x200: misaligned=0.
- Wrap and mid-run reset, with ADDR_W=8, PC_STEP=4:
  - From pc=0xFC, next pc=0x00.
  - Asserting rst while pend_valid=1 gives ce=0, pc=0. After release, the old pending target is never loaded.
